data_mem_pp: RTL and testbench
==============================

DATA_MEM_PP -- requirements
Module: data_mem_pp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width (one complex I/Q pair of 16+16 bits).
REQ-002 SHALL have parameter DEPTH, default 64, meaning words per bank; legal range 2..256.
REQ-003 SHALL have parameter INST_W, default 64, meaning instruction width; only inst[23:0] is decoded.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, synchronous and active-low.
REQ-006 SHALL have port wren  input  1  meaning write request.
REQ-007 SHALL have port wr_stream  input  1  meaning, when high with wren, write to the internal pointer and ignore the instruction address.
REQ-008 SHALL have port rden  input  1  meaning read request for both read ports.
REQ-009 SHALL have port swap  input  1  meaning exchange the read bank and write bank roles.
REQ-010 SHALL have port inst  input  INST_W  meaning the instruction: write address in [23:16], port-1 read address in [15:8], port-0 read address in [7:0].
REQ-011 SHALL have port wdata  input  DATA_W  meaning write data.
REQ-012 SHALL have port rdata0  output  DATA_W  meaning read data for port 0.
REQ-013 SHALL have port rdata1  output  DATA_W  meaning read data for port 1.
REQ-014 SHALL have port rvalid  output  1  meaning rdata0 and rdata1 are valid this cycle.
REQ-015 SHALL have port bank_sel  output  1  meaning the index of the bank currently being read; writes go to the other bank.
REQ-016 SHALL have port wr_full  output  1  meaning the stream pointer has filled the write bank.

Function
REQ-017 SHALL contain two banks of DEPTH x DATA_W: bank bank_sel is read-only, bank ~bank_sel is write-only.
REQ-018 SHALL, on a non-stream write (wren=1, wr_stream=0), store wdata at inst[23:16] in the write bank; the stream pointer is unchanged.
REQ-019 SHALL, on a stream write (wren=1, wr_stream=1, wr_full=0), store wdata at wptr in the write bank and then increment wptr.
REQ-020 SHALL set wr_full=1 on the edge that performs the stream write with wptr=DEPTH-1; wptr then holds at DEPTH-1.
REQ-021 SHALL drop stream writes while wr_full=1; non-stream writes are still accepted.
REQ-022 SHALL drop any write whose address is >= DEPTH, with no side effects.
REQ-023 SHALL, on rden=1, register the read bank at inst[7:0] into rdata0 and at inst[15:8] into rdata1, with rvalid=1 on the next cycle (read latency 1).
REQ-024 SHALL return 0 on a read port whose address is >= DEPTH; rvalid is still asserted.
REQ-025 SHALL, on rden=0, hold rdata0/rdata1 at their last values and drive rvalid=0 next cycle.
REQ-026 SHALL, on swap=1, toggle bank_sel at that edge, clear wptr to 0, and clear wr_full to 0.
REQ-027 SHALL, when swap coincides with a write, commit the write to the pre-swap write bank.
REQ-028 SHALL, when swap coincides with a read, return data from the pre-swap read bank.
REQ-029 SHALL, when swap coincides with a stream write, commit that write at the old wptr; the post-swap wptr is 0.
REQ-030 SHALL never allow a read to observe a same-cycle write, because the two always target different banks.
REQ-031 SHALL infer the banks as RAM without reset (block or distributed RAM, chosen by synthesis).

Reset
REQ-032 SHALL, when rst=0 at a clock edge, set rdata0=0, rdata1=0, rvalid=0, bank_sel=0, wptr=0, wr_full=0.
REQ-033 SHALL ignore wren/rden/swap during reset, leave memory contents unchanged, and abandon any read in flight (rvalid=0 on the following cycle).

Verification
REQ-034 SHALL be verified by a non-stream fill and swap test: after reset, write 1,3,5,7,9,11 to addresses 0..5, pulse swap, then read with inst[15:0]=0x0100, 0x0302, 0x0504 -> (rdata1,rdata0)=(3,1),(7,5),(11,9) with rvalid high one cycle after each request.
REQ-035 SHALL be verified by a stream-fill test: stream DEPTH+2 words 100..165 (DEPTH=64) -> wr_full rises after word 163; words 164..165 are dropped; after swap, address 63 reads 163.
REQ-036 SHALL be verified by a simultaneous-event test: in one cycle, swap + write 0xAA to address 2 + read address 2 -> the read returns the old read-bank value; on the next swap, address 2 reads 0xAA.
REQ-037 SHALL be verified by an out-of-range test with DEPTH=16: write to address 20 and read ports at 20/3 -> no bank contents change, rdata0=mem[3], rdata1=0.
REQ-038 SHALL be verified by a reset-mid-operation test: assert rst=0 during a streaming fill with rden=1 -> next cycle all outputs are 0; after release, a stream write lands at address 0.

Source files
------------

// File: rtl/data_mem_pp.sv
// Ping-pong data memory: two banks, one read-only and one write-only, whose roles
// exchange on swap. Writes use either an instruction address or a stream pointer.
// Reads come back one cycle after the request.
module data_mem_pp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned INST_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wren,
  input  logic              wr_stream,
  input  logic              rden,
  input  logic              swap,
  input  logic [INST_W-1:0] inst,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid,
  output logic              bank_sel,
  output logic              wr_full
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LAST = DEPTH - 1;

  // Bank storage, no reset so it maps onto RAM
  logic [DATA_W-1:0] mem_q [2][DEPTH];

  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              rvalid_q, rvalid_d;
  logic              bank_sel_q, bank_sel_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic              wr_full_q, wr_full_d;

  logic [7:0]        waddr_c, raddr0_c, raddr1_c;
  logic              wr_en_c;
  logic [AW-1:0]     wr_idx_c;
  logic              wr_bank_c;
  logic              stream_ok_c;
  logic              unused_inst_c;

  assign waddr_c       = inst[23:16];
  assign raddr1_c      = inst[15:8];
  assign raddr0_c      = inst[7:0];
  assign wr_bank_c     = ~bank_sel_q;
  assign unused_inst_c = ^inst[INST_W-1:24];
  assign stream_ok_c   = wren & wr_stream & ~wr_full_q;

  // Write address selection and range/full qualification; nothing lands during reset
  always_comb begin
    wr_en_c  = 1'b0;
    wr_idx_c = wptr_q;
    if (rst && wren) begin
      if (wr_stream) begin
        wr_en_c  = ~wr_full_q;
        wr_idx_c = wptr_q;
      end else begin
        wr_en_c  = (32'(waddr_c) < DEPTH);
        wr_idx_c = AW'(waddr_c);
      end
    end
  end

  // Write port into the bank not currently being read
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_bank_c][wr_idx_c] <= wdata;
    end
  end

  // Next-state: read capture from the pre-swap read bank, stream pointer, bank swap
  always_comb begin
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    rvalid_d   = rden;
    bank_sel_d = bank_sel_q;
    wptr_d     = wptr_q;
    wr_full_d  = wr_full_q;

    if (rden) begin
      rdata0_d = (32'(raddr0_c) < DEPTH) ? mem_q[bank_sel_q][AW'(raddr0_c)] : '0;
      rdata1_d = (32'(raddr1_c) < DEPTH) ? mem_q[bank_sel_q][AW'(raddr1_c)] : '0;
    end

    if (stream_ok_c) begin
      if (wptr_q == AW'(LAST)) begin
        wr_full_d = 1'b1;
      end else begin
        wptr_d = wptr_q + AW'(1);
      end
    end

    if (swap) begin
      bank_sel_d = ~bank_sel_q;
      wptr_d     = '0;
      wr_full_d  = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      rvalid_q   <= 1'b0;
      bank_sel_q <= 1'b0;
      wptr_q     <= '0;
      wr_full_q  <= 1'b0;
    end else begin
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      rvalid_q   <= rvalid_d;
      bank_sel_q <= bank_sel_d;
      wptr_q     <= wptr_d;
      wr_full_q  <= wr_full_d;
    end
  end

  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign rvalid   = rvalid_q;
  assign bank_sel = bank_sel_q;
  assign wr_full  = wr_full_q;

endmodule

// File: tb/tb_data_mem_pp.sv
// Bench for data_mem_pp: a DEPTH=64 and a DEPTH=16 instance share one stimulus
// stream; a behavioural model per instance is compared every cycle, plus
// hand-computed expectations for the directed scenarios.
module tb_data_mem_pp;

  logic        clk;
  logic        rst;
  logic        wren, wr_stream, rden, swap;
  logic [63:0] inst;
  logic [31:0] wdata;

  logic [31:0] rd0 [2];
  logic [31:0] rd1 [2];
  logic        rv  [2];
  logic        bs  [2];
  logic        wf  [2];

  int n_checks;
  int n_fail;
  bit cmp_en;

  data_mem_pp #(.DATA_W(32), .DEPTH(64), .INST_W(64)) u_dut64 (
    .clk(clk), .rst(rst), .wren(wren), .wr_stream(wr_stream), .rden(rden),
    .swap(swap), .inst(inst), .wdata(wdata),
    .rdata0(rd0[0]), .rdata1(rd1[0]), .rvalid(rv[0]), .bank_sel(bs[0]), .wr_full(wf[0])
  );

  data_mem_pp #(.DATA_W(32), .DEPTH(16), .INST_W(64)) u_dut16 (
    .clk(clk), .rst(rst), .wren(wren), .wr_stream(wr_stream), .rden(rden),
    .swap(swap), .inst(inst), .wdata(wdata),
    .rdata0(rd0[1]), .rdata1(rd1[1]), .rvalid(rv[1]), .bank_sel(bs[1]), .wr_full(wf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [2][2][256];
  bit          m_kn  [2][2][256];
  bit          m_sel [2];
  int          m_wptr[2];
  bit          m_full[2];
  logic [31:0] e_rd0 [2];
  logic [31:0] e_rd1 [2];
  bit          e_k0  [2];
  bit          e_k1  [2];
  bit          e_rv  [2];

  function automatic int depth_of(input int k);
    return (k == 0) ? 64 : 16;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int d;
      int a0, a1, aw;
      d = depth_of(k);
      if (!rst) begin
        e_rd0[k] = 0; e_rd1[k] = 0; e_k0[k] = 1; e_k1[k] = 1; e_rv[k] = 0;
        m_sel[k] = 0; m_wptr[k] = 0; m_full[k] = 0;
      end else begin
        e_rv[k] = rden;
        if (rden) begin
          a0 = int'(inst[7:0]);
          a1 = int'(inst[15:8]);
          if (a0 < d) begin e_rd0[k] = m_mem[k][m_sel[k]][a0]; e_k0[k] = m_kn[k][m_sel[k]][a0]; end
          else begin e_rd0[k] = 0; e_k0[k] = 1; end
          if (a1 < d) begin e_rd1[k] = m_mem[k][m_sel[k]][a1]; e_k1[k] = m_kn[k][m_sel[k]][a1]; end
          else begin e_rd1[k] = 0; e_k1[k] = 1; end
        end
        if (wren) begin
          if (wr_stream) begin
            if (!m_full[k]) begin
              m_mem[k][!m_sel[k]][m_wptr[k]] = wdata;
              m_kn[k][!m_sel[k]][m_wptr[k]]  = 1;
              if (m_wptr[k] == d - 1) m_full[k] = 1;
              else m_wptr[k] = m_wptr[k] + 1;
            end
          end else begin
            aw = int'(inst[23:16]);
            if (aw < d) begin
              m_mem[k][!m_sel[k]][aw] = wdata;
              m_kn[k][!m_sel[k]][aw]  = 1;
            end
          end
        end
        if (swap) begin
          m_sel[k] = !m_sel[k]; m_wptr[k] = 0; m_full[k] = 0;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("rvalid[%0d]", k),   32'(rv[k]), 32'(e_rv[k]));
        check($sformatf("bank_sel[%0d]", k), 32'(bs[k]), 32'(m_sel[k]));
        check($sformatf("wr_full[%0d]", k),  32'(wf[k]), 32'(m_full[k]));
        if (e_k0[k]) check($sformatf("rdata0[%0d]", k), rd0[k], e_rd0[k]);
        if (e_k1[k]) check($sformatf("rdata1[%0d]", k), rd1[k], e_rd1[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit we, input bit st, input bit re, input bit sw,
                     input logic [7:0] wa, input logic [7:0] ra1, input logic [7:0] ra0,
                     input logic [31:0] wd);
    wren = we; wr_stream = st; rden = re; swap = sw;
    inst = {40'h0, wa, ra1, ra0};
    wdata = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 8'h0, 8'h0, 8'h0, 32'h0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cmp_en = 0;
    rst = 1'b0;
    wren = 0; wr_stream = 0; rden = 0; swap = 0; inst = '0; wdata = '0;
    idle();
    cmp_en = 1;
    idle();
    check("reset_rdata0", rd0[0], 32'h0);
    check("reset_rvalid", 32'(rv[0]), 32'h0);
    check("reset_bank_sel", 32'(bs[0]), 32'h0);
    check("reset_wr_full", 32'(wf[0]), 32'h0);
    rst = 1'b1;

    // Non-stream fill then swap
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 8'(i), 8'h0, 8'h0, 32'(2 * i + 1));
    cyc(0, 0, 0, 1, 8'h0, 8'h0, 8'h0, 32'h0);
    check("swap_bank_sel", 32'(bs[0]), 32'h1);
    cyc(0, 0, 1, 0, 8'h0, 8'h01, 8'h00, 32'h0);
    check("fill_rd_01_r1", rd1[0], 32'd3);
    check("fill_rd_01_r0", rd0[0], 32'd1);
    check("fill_rd_01_rv", 32'(rv[0]), 32'h1);
    cyc(0, 0, 1, 0, 8'h0, 8'h03, 8'h02, 32'h0);
    check("fill_rd_23_r1", rd1[0], 32'd7);
    check("fill_rd_23_r0", rd0[0], 32'd5);
    cyc(0, 0, 1, 0, 8'h0, 8'h05, 8'h04, 32'h0);
    check("fill_rd_45_r1", rd1[0], 32'd11);
    check("fill_rd_45_r0", rd0[0], 32'd9);
    idle();
    check("idle_rvalid", 32'(rv[0]), 32'h0);
    check("idle_hold_r0", rd0[0], 32'd9);

    // Stream fill past capacity
    for (int i = 0; i < 66; i++) begin
      cyc(1, 1, 0, 0, 8'h0, 8'h0, 8'h0, 32'(100 + i));
      if (i == 62) check("stream_not_full_162", 32'(wf[0]), 32'h0);
      if (i == 63) check("stream_full_163", 32'(wf[0]), 32'h1);
      if (i == 15) check("stream16_full", 32'(wf[1]), 32'h1);
    end
    cyc(0, 0, 0, 1, 8'h0, 8'h0, 8'h0, 32'h0);
    check("swap_clears_full", 32'(wf[0]), 32'h0);
    cyc(0, 0, 1, 0, 8'h0, 8'd0, 8'd63, 32'h0);
    check("stream_addr63", rd0[0], 32'd163);
    check("stream_addr0", rd1[0], 32'd100);

    // Simultaneous swap + write + read
    cyc(1, 0, 1, 1, 8'd2, 8'd0, 8'd2, 32'hAA);
    check("simul_old_bank", rd0[0], 32'd102);
    cyc(0, 0, 1, 0, 8'h0, 8'd0, 8'd2, 32'h0);
    check("simul_new_value", rd0[0], 32'hAA);

    // Out-of-range write/read on the DEPTH=16 instance
    cyc(1, 0, 1, 0, 8'd20, 8'd20, 8'd3, 32'h55);
    check("oor16_r0", rd0[1], 32'd7);
    check("oor16_r1", rd1[1], 32'h0);
    check("oor16_rv", 32'(rv[1]), 32'h1);

    // Reset in the middle of a streaming fill with reads active
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 8'h0, 8'd1, 8'd0, 32'(200 + i));
    rst = 1'b0;
    cyc(1, 1, 1, 1, 8'h0, 8'd1, 8'd0, 32'h99);
    check("rst_mid_r0", rd0[0], 32'h0);
    check("rst_mid_r1", rd1[0], 32'h0);
    check("rst_mid_rv", 32'(rv[0]), 32'h0);
    check("rst_mid_bs", 32'(bs[0]), 32'h0);
    check("rst_mid_wf", 32'(wf[0]), 32'h0);
    rst = 1'b1;
    cyc(1, 1, 0, 0, 8'h0, 8'h0, 8'h0, 32'h77);
    cyc(0, 0, 0, 1, 8'h0, 8'h0, 8'h0, 32'h0);
    cyc(0, 0, 1, 0, 8'h0, 8'd1, 8'd0, 32'h0);
    check("rst_stream_addr0", rd0[0], 32'h77);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      cyc(($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 4),
          8'($urandom_range(0, 79)), 8'($urandom_range(0, 79)),
          8'($urandom_range(0, 79)), $urandom);
    end
    rst = 1'b1;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
